// File: rtl/wb_regfile.sv
// Write-back stage with integrated integer register file.
// Formats load data from MEM/WB, commits the result to the file, and serves
// two decode read ports with same-cycle write-through bypass. A registered
// commit trace and a commit counter are provided for debug visibility.
// The block has no handshake: every MEM/WB cycle is consumed, and a bubble
// is simply MEM_WB_reg_write_en=0.
module wb_regfile #(
   parameter int REG_WIDTH      = 32,
   parameter int REG_ADDR_WIDTH = 5,
   parameter int CNT_WIDTH      = 32
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic [REG_WIDTH-1:0]      MEM_WB_alu_out,
   input  logic [REG_WIDTH-1:0]      MEM_WB_dmem_data,
   input  logic [2:0]                MEM_WB_funct3,
   input  logic [REG_ADDR_WIDTH-1:0] MEM_WB_rd,
   input  logic                      MEM_WB_reg_write_en,
   input  logic                      MEM_WB_wb_sel,
   input  logic [REG_ADDR_WIDTH-1:0] ID_rs1,
   input  logic [REG_ADDR_WIDTH-1:0] ID_rs2,
   output logic [REG_WIDTH-1:0]      ID_rs1_data,
   output logic [REG_WIDTH-1:0]      ID_rs2_data,
   output logic [REG_WIDTH-1:0]      wb_data,
   output logic                      wb_commit_valid,
   output logic [REG_ADDR_WIDTH-1:0] wb_commit_rd,
   output logic [REG_WIDTH-1:0]      wb_commit_data,
   output logic [CNT_WIDTH-1:0]      wb_commit_cnt
);

   localparam int NUM_REGS = 1 << REG_ADDR_WIDTH;
   localparam logic [CNT_WIDTH-1:0] CNT_ONE = 1;

   logic [REG_WIDTH-1:0] regs [NUM_REGS];

   logic [1:0]           off;
   logic [7:0]           ld_byte;
   logic [15:0]          ld_half;
   logic [REG_WIDTH-1:0] ld_fmt;
   logic                 ld_signed;
   logic                 commit;

   assign off       = MEM_WB_alu_out[1:0];
   // funct3[2] set means the unsigned variant (LBU/LHU)
   assign ld_signed = ~MEM_WB_funct3[2];

   // Pick the addressed byte and halfword out of the aligned memory word;
   // off[0] is ignored for halfwords since misaligned loads do not trap here.
   always_comb begin
      ld_byte = MEM_WB_dmem_data[7:0];
      case (off)
         2'd0: ld_byte = MEM_WB_dmem_data[7:0];
         2'd1: ld_byte = MEM_WB_dmem_data[15:8];
         2'd2: ld_byte = MEM_WB_dmem_data[23:16];
         2'd3: ld_byte = MEM_WB_dmem_data[31:24];
         default: ld_byte = MEM_WB_dmem_data[7:0];
      endcase
      ld_half = off[1] ? MEM_WB_dmem_data[31:16] : MEM_WB_dmem_data[15:0];
   end

   // Size/sign formatting of the loaded value; codes with funct3[1] set load a full word.
   always_comb begin
      ld_fmt = MEM_WB_dmem_data;
      case (MEM_WB_funct3)
         3'b000, 3'b100: ld_fmt = {{(REG_WIDTH-8){ld_signed & ld_byte[7]}}, ld_byte};
         3'b001, 3'b101: ld_fmt = {{(REG_WIDTH-16){ld_signed & ld_half[15]}}, ld_half};
         default:        ld_fmt = MEM_WB_dmem_data;
      endcase
   end

   // Write-back source mux; driven every cycle so it can feed forwarding paths.
   always_comb begin
      wb_data = MEM_WB_wb_sel ? ld_fmt : MEM_WB_alu_out;
   end

   // x0 is hard-wired, and a write presented during reset is discarded.
   assign commit = MEM_WB_reg_write_en & (MEM_WB_rd != '0) & reset_n;

   // Register file update and commit trace; reset clears every entry.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs[i] <= '0;
         end
         wb_commit_valid <= 1'b0;
         wb_commit_rd    <= '0;
         wb_commit_data  <= '0;
         wb_commit_cnt   <= '0;
      end else if (commit) begin
         regs[MEM_WB_rd] <= wb_data;
         wb_commit_valid <= 1'b1;
         wb_commit_rd    <= MEM_WB_rd;
         wb_commit_data  <= wb_data;
         wb_commit_cnt   <= wb_commit_cnt + CNT_ONE;
      end else begin
         wb_commit_valid <= 1'b0;
      end
   end

   // Read port 1: x0 reads zero, otherwise bypass the in-flight write, else the file.
   always_comb begin
      ID_rs1_data = regs[ID_rs1];
      if (ID_rs1 == '0) begin
         ID_rs1_data = '0;
      end else if (MEM_WB_reg_write_en && (ID_rs1 == MEM_WB_rd)) begin
         ID_rs1_data = wb_data;
      end
   end

   // Read port 2: same selection as port 1.
   always_comb begin
      ID_rs2_data = regs[ID_rs2];
      if (ID_rs2 == '0) begin
         ID_rs2_data = '0;
      end else if (MEM_WB_reg_write_en && (ID_rs2 == MEM_WB_rd)) begin
         ID_rs2_data = wb_data;
      end
   end

endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile: reset state, load formatting table, bypass,
// x0 handling, back-to-back writes, reset during a write and counter wrap
// (on a second instance built with a 4-bit counter).
module tb_wb_regfile;

   localparam int W  = 32;
   localparam int AW = 5;

   // ---------------- clock / reset ----------------
   logic clk;
   logic reset_n;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- DUT signals ----------------
   logic [W-1:0]  alu_out;
   logic [W-1:0]  dmem_data;
   logic [2:0]    funct3;
   logic [AW-1:0] rd;
   logic          we;
   logic          wb_sel;
   logic [AW-1:0] rs1;
   logic [AW-1:0] rs2;
   logic [W-1:0]  rs1_data, rs2_data, wb_data;
   logic          c_valid;
   logic [AW-1:0] c_rd;
   logic [W-1:0]  c_data;
   logic [31:0]   c_cnt;

   logic [W-1:0]  s_rs1_data, s_rs2_data, s_wb_data;
   logic          s_valid;
   logic [AW-1:0] s_rd;
   logic [W-1:0]  s_data;
   logic [3:0]    s_cnt;

   wb_regfile #(.REG_WIDTH(W), .REG_ADDR_WIDTH(AW), .CNT_WIDTH(32)) dut (
      .clk(clk), .reset_n(reset_n),
      .MEM_WB_alu_out(alu_out), .MEM_WB_dmem_data(dmem_data),
      .MEM_WB_funct3(funct3), .MEM_WB_rd(rd),
      .MEM_WB_reg_write_en(we), .MEM_WB_wb_sel(wb_sel),
      .ID_rs1(rs1), .ID_rs2(rs2),
      .ID_rs1_data(rs1_data), .ID_rs2_data(rs2_data), .wb_data(wb_data),
      .wb_commit_valid(c_valid), .wb_commit_rd(c_rd),
      .wb_commit_data(c_data), .wb_commit_cnt(c_cnt)
   );

   wb_regfile #(.REG_WIDTH(W), .REG_ADDR_WIDTH(AW), .CNT_WIDTH(4)) dut_small (
      .clk(clk), .reset_n(reset_n),
      .MEM_WB_alu_out(alu_out), .MEM_WB_dmem_data(dmem_data),
      .MEM_WB_funct3(funct3), .MEM_WB_rd(rd),
      .MEM_WB_reg_write_en(we), .MEM_WB_wb_sel(wb_sel),
      .ID_rs1(rs1), .ID_rs2(rs2),
      .ID_rs1_data(s_rs1_data), .ID_rs2_data(s_rs2_data), .wb_data(s_wb_data),
      .wb_commit_valid(s_valid), .wb_commit_rd(s_rd),
      .wb_commit_data(s_data), .wb_commit_cnt(s_cnt)
   );

   // ---------------- scoreboard ----------------
   logic [W-1:0]  exp_q[$];
   logic [AW-1:0] exp_rd_q[$];
   logic [W-1:0]  model [32];
   logic [31:0]   exp_cnt;
   int            n_checks;
   int            n_fail;

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      we      = 1'b0;
      rd      = '0;
      alu_out = '0;
      wb_sel  = 1'b0;
   endtask

   task automatic drive_wb(input logic [AW-1:0] d_rd, input logic d_sel,
                           input logic [W-1:0] d_alu, input logic [W-1:0] d_dmem,
                           input logic [2:0] d_f3);
      we        = 1'b1;
      rd        = d_rd;
      wb_sel    = d_sel;
      alu_out   = d_alu;
      dmem_data = d_dmem;
      funct3    = d_f3;
   endtask

   // Compare the commit trace and counters after an edge against the scoreboard.
   task automatic check_trace();
      logic          exp_valid;
      logic [W-1:0]  d;
      logic [AW-1:0] r;
      exp_valid = (exp_q.size() != 0);
      check32("commit_valid", {31'd0, c_valid}, {31'd0, exp_valid});
      if (exp_valid) begin
         d = exp_q.pop_front();
         r = exp_rd_q.pop_front();
         check32("commit_data", c_data, d);
         check32("commit_rd", {27'd0, c_rd}, {27'd0, r});
      end
      check32("commit_cnt", c_cnt, exp_cnt);
      check32("commit_cnt4", {28'd0, s_cnt}, {28'd0, exp_cnt[3:0]});
   endtask

   // Clock one edge with the currently driven inputs, updating the model,
   // then return the inputs to a bubble and check the trace.
   task automatic commit_cycle(input logic [W-1:0] exp_wb);
      if (!reset_n) begin
         for (int i = 0; i < 32; i++) model[i] = '0;
         exp_q.delete();
         exp_rd_q.delete();
         exp_cnt = '0;
      end else if (we && (rd != 0)) begin
         model[rd] = exp_wb;
         exp_q.push_back(exp_wb);
         exp_rd_q.push_back(rd);
         exp_cnt = exp_cnt + 1;
      end
      tick();
      idle();
      check_trace();
   endtask

   task automatic read_check(input string name, input logic [AW-1:0] a1, input logic [AW-1:0] a2);
      rs1 = a1;
      rs2 = a2;
      #1;
      check32({name, "_rs1"}, rs1_data, (a1 == 0) ? 32'd0 : model[a1]);
      check32({name, "_rs2"}, rs2_data, (a2 == 0) ? 32'd0 : model[a2]);
   endtask

   // ---------------- load formatting table ----------------
   typedef struct {
      logic [2:0]  f3;
      logic [31:0] alu;
      logic [31:0] dmem;
      logic [31:0] exp;
   } ld_vec_t;

   ld_vec_t ld_vecs [10];

   // ---------------- main test ----------------
   initial begin
      logic [31:0] cnt_before;
      n_checks = 0;
      n_fail   = 0;
      exp_cnt  = '0;
      for (int i = 0; i < 32; i++) model[i] = '0;

      ld_vecs[0] = '{3'b000, 32'h0000_1000, 32'h8070F0A5, 32'hFFFFFFA5}; // LB off0
      ld_vecs[1] = '{3'b100, 32'h0000_1001, 32'h8070F0A5, 32'h000000F0}; // LBU off1
      ld_vecs[2] = '{3'b001, 32'h0000_1002, 32'h8070F0A5, 32'hFFFF8070}; // LH off2
      ld_vecs[3] = '{3'b101, 32'h0000_1003, 32'h8070F0A5, 32'h00008070}; // LHU off3
      ld_vecs[4] = '{3'b010, 32'h0000_1000, 32'h8070F0A5, 32'h8070F0A5}; // LW
      ld_vecs[5] = '{3'b000, 32'h0000_1003, 32'h8070F0A5, 32'hFFFFFF80}; // LB off3
      ld_vecs[6] = '{3'b100, 32'h0000_1002, 32'h8070F0A5, 32'h00000070}; // LBU off2
      ld_vecs[7] = '{3'b001, 32'h0000_1001, 32'h8070F0A5, 32'hFFFFF0A5}; // LH off1 -> low half
      ld_vecs[8] = '{3'b101, 32'h0000_1000, 32'h8070F0A5, 32'h0000F0A5}; // LHU off0
      ld_vecs[9] = '{3'b111, 32'h0000_1001, 32'h8070F0A5, 32'h8070F0A5}; // word code 111

      idle();
      dmem_data = '0;
      funct3    = 3'b010;
      rs1       = '0;
      rs2       = '0;
      reset_n   = 1'b0;
      tick();
      tick();
      reset_n = 1'b1;

      // Reset state: every address reads zero on both ports.
      for (int i = 0; i < 32; i++) begin
         read_check("reset_read", i[AW-1:0], 5'(31 - i));
      end
      check32("reset_valid", {31'd0, c_valid}, 32'd0);
      check32("reset_cnt", c_cnt, 32'd0);

      // ALU write to x5 with same-cycle bypass on rs1.
      drive_wb(5'd5, 1'b0, 32'hDEADBEEF, 32'h0, 3'b010);
      rs1 = 5'd5;
      rs2 = 5'd6;
      #1;
      check32("alu_wb_data", wb_data, 32'hDEADBEEF);
      check32("alu_bypass_rs1", rs1_data, 32'hDEADBEEF);
      check32("alu_nobypass_rs2", rs2_data, 32'd0);
      commit_cycle(32'hDEADBEEF);
      read_check("alu_file", 5'd5, 5'd5);

      // Load formatting table, written to x7 and read back through both ports.
      for (int i = 0; i < 10; i++) begin
         drive_wb(5'd7, 1'b1, ld_vecs[i].alu, ld_vecs[i].dmem, ld_vecs[i].f3);
         rs1 = 5'd7;
         #1;
         check32($sformatf("load%0d_wb_data", i), wb_data, ld_vecs[i].exp);
         check32($sformatf("load%0d_bypass", i), rs1_data, ld_vecs[i].exp);
         commit_cycle(ld_vecs[i].exp);
         read_check($sformatf("load%0d_file", i), 5'd7, 5'd7);
      end

      // wb_data is driven without a write request, and no bypass happens then.
      we        = 1'b0;
      rd        = 5'd7;
      wb_sel    = 1'b0;
      alu_out   = 32'hCAFE0001;
      rs1       = 5'd7;
      #1;
      check32("nowe_wb_data", wb_data, 32'hCAFE0001);
      check32("nowe_no_bypass", rs1_data, model[7]);
      commit_cycle(32'h0);

      // Write to x0 is dropped; x0 reads zero during and after.
      cnt_before = exp_cnt;
      drive_wb(5'd0, 1'b0, 32'h0000_1234, 32'h0, 3'b010);
      rs1 = 5'd0;
      rs2 = 5'd0;
      #1;
      check32("x0_wb_data", wb_data, 32'h0000_1234);
      check32("x0_same_rs1", rs1_data, 32'd0);
      check32("x0_same_rs2", rs2_data, 32'd0);
      commit_cycle(32'h0);
      read_check("x0_next", 5'd0, 5'd0);
      check32("x0_cnt_hold", c_cnt, cnt_before);

      // Back-to-back writes to x3; second value visible via bypass on rs2.
      cnt_before = exp_cnt;
      drive_wb(5'd3, 1'b0, 32'h11, 32'h0, 3'b010);
      commit_cycle(32'h11);
      drive_wb(5'd3, 1'b0, 32'h22, 32'h0, 3'b010);
      rs2 = 5'd3;
      rs1 = 5'd3;
      #1;
      check32("b2b_bypass_rs2", rs2_data, 32'h22);
      check32("b2b_bypass_rs1", rs1_data, 32'h22);
      commit_cycle(32'h22);
      read_check("b2b_file", 5'd3, 5'd3);
      check32("b2b_cnt_plus2", c_cnt, cnt_before + 32'd2);

      // Reset in the same cycle as a write to x9: write discarded, file cleared.
      drive_wb(5'd9, 1'b0, 32'h55, 32'h0, 3'b010);
      reset_n = 1'b0;
      commit_cycle(32'h55);
      reset_n = 1'b1;
      read_check("rst_mid_x9", 5'd9, 5'd5);
      check32("rst_mid_cnt", c_cnt, 32'd0);

      // Counter wrap on the 4-bit instance: 15 commits, then one more.
      for (int i = 1; i <= 15; i++) begin
         drive_wb(5'(i), 1'b0, 32'h100 + i, 32'h0, 3'b010);
         commit_cycle(32'h100 + i);
      end
      check32("wrap_cnt4_full", {28'd0, s_cnt}, 32'd15);
      drive_wb(5'd20, 1'b0, 32'hA5A5_0000, 32'h0, 3'b010);
      commit_cycle(32'hA5A5_0000);
      check32("wrap_cnt4_zero", {28'd0, s_cnt}, 32'd0);
      check32("wrap_cnt32", c_cnt, 32'd16);
      read_check("wrap_file", 5'd20, 5'd15);

      // ---------------- final report ----------------
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   // Hard time limit so the run always ends.
   initial begin
      #200000;
      $display("FAIL timeout: simulation did not reach the end of test");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
- Write-back end of the MEM/WB pipeline interface: consumes the MEM/WB register outputs, selects and formats the write-back value, and commits it to the integer register file.
- Provides two decode-stage read ports with same-cycle write-through bypass.
- Provides a one-cycle-delayed commit trace and a write-commit counter for debug and verification.
- Sits between the MEM/WB register and the ID stage, and replaces the standalone register file.

Parameters:
- REG_WIDTH, 32, datapath width. Load formatting is defined for 32 only.
- REG_ADDR_WIDTH, 5, register address width. The file holds 2**REG_ADDR_WIDTH entries.
- CNT_WIDTH, 32, width of the commit counter.

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  synchronous active-low reset.
- MEM_WB_alu_out  in  REG_WIDTH  ALU result; also the load address, of which bits [1:0] are the byte offset.
- MEM_WB_dmem_data  in  REG_WIDTH  raw aligned 32-bit word read from data memory.
- MEM_WB_funct3  in  3  load size/sign code.
- MEM_WB_rd  in  REG_ADDR_WIDTH  destination register.
- MEM_WB_reg_write_en  in  1  write request.
- MEM_WB_wb_sel  in  1  write-back source: 0 = ALU result, 1 = formatted load data.
- ID_rs1  in  REG_ADDR_WIDTH  read address, port 1.
- ID_rs2  in  REG_ADDR_WIDTH  read address, port 2.
- ID_rs1_data  out  REG_WIDTH  read data, port 1 (combinational).
- ID_rs2_data  out  REG_WIDTH  read data, port 2 (combinational).
- wb_data  out  REG_WIDTH  current-cycle write-back value (combinational), for forwarding.
- wb_commit_valid  out  1  registered: a write committed in the previous cycle.
- wb_commit_rd  out  REG_ADDR_WIDTH  registered: destination of that write.
- wb_commit_data  out  REG_WIDTH  registered: value of that write.
- wb_commit_cnt  out  CNT_WIDTH  count of committed writes.

Behaviour:
- Reset (reset_n=0 at a rising clk edge):
  - All register-file entries are cleared to 0.
  - wb_commit_valid, wb_commit_rd, wb_commit_data and wb_commit_cnt are cleared to 0.
  - Reset applied mid-operation discards the write presented in that cycle: there is no file update, no commit-trace update and no count increment.
  - Combinational outputs follow their inputs during reset; they read 0 from the file because the file is cleared.
- Load formatting, with off = MEM_WB_alu_out[1:0]:
  - 000 LB: byte at off, sign-extended.
  - 100 LBU: byte at off, zero-extended.
  - 001 LH: halfword at off[1] (off[0] ignored, no misalign trap), sign-extended.
  - 101 LHU: halfword at off[1], zero-extended.
  - 010, 011, 110, 111: full word, unmodified.
  - Byte k of the word = dmem_data[8k+7:8k].
- wb_data = MEM_WB_wb_sel ? formatted load : MEM_WB_alu_out. This value is driven regardless of reg_write_en.
- commit = MEM_WB_reg_write_en & (MEM_WB_rd != 0) & reset_n.
- On a rising edge with commit=1:
  - regs[MEM_WB_rd] <= wb_data.
  - wb_commit_valid <= 1, wb_commit_rd <= MEM_WB_rd, wb_commit_data <= wb_data.
  - wb_commit_cnt <= wb_commit_cnt + 1, wrapping modulo 2**CNT_WIDTH.
- On a rising edge with commit=0 and reset_n=1: wb_commit_valid <= 0; wb_commit_rd, wb_commit_data and wb_commit_cnt hold.
- x0: writes to rd=0 are dropped and not counted. Reads of address 0 always return 0, including when bypassing.
- Read ports, for each p in {1,2}:
  - If ID_rsp == 0: 0.
  - Else if MEM_WB_reg_write_en and ID_rsp == MEM_WB_rd: wb_data (write-through bypass, same cycle).
  - Else: regs[ID_rsp].
  - Both ports may address the same register simultaneously; both return the same value.
- Latency:
  - Write-back to file: 1 edge.
  - Read: 0 cycles (combinational).
  - Commit trace: valid the cycle after the write edge.
- No stall input: every cycle presented by MEM/WB is consumed. A bubble is represented by reg_write_en=0.

Test Plan:
- Reset with reset_n=0 for 2 edges, then read all 32 addresses on both ports -> all 0; wb_commit_valid=0 and wb_commit_cnt=0.
- ALU write rd=5, alu_out=0xDEADBEEF, wb_sel=0, with ID_rs1=5 in the same cycle -> ID_rs1_data=0xDEADBEEF via bypass. After the edge: file read of x5 = 0xDEADBEEF, wb_commit_valid=1, wb_commit_rd=5, wb_commit_cnt=1.
- Loads with dmem_data=0x8070F0A5, wb_sel=1, rd=7:
  - LB off=0 -> 0xFFFFFFA5.
  - LBU off=1 -> 0x000000F0.
  - LH off=2 -> 0xFFFF8070.
  - LHU off=3 -> 0x00008070.
  - LW -> 0x8070F0A5.
- Write rd=0 with write_en=1, alu_out=0x1234 -> x0 reads 0 on both ports in the same and next cycle; wb_commit_valid=0; count unchanged.
- Back-to-back writes to x3 (0x11) then x3 (0x22), with ID_rs2=3 during the second cycle -> ID_rs2_data=0x22; after the edges x3=0x22 and wb_commit_cnt has increased by 2.
- Assert reset_n=0 in the same cycle as a write of rd=9, value 0x55 -> x9=0 and wb_commit_cnt=0. Separately, preload the counter to all-ones via 2**CNT_WIDTH-1 commits (CNT_WIDTH=4 build), then one more commit -> wb_commit_cnt wraps to 0.
